// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed hex 7-segment display path:
// the segment table, the scan-select codes and the receive FSM states.
package seg7_pkg;

    // Segment patterns, bit6..bit0 = g,f,e,d,c,b,a, active-high
    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b1111100;
    localparam logic [6:0] SEG_C = 7'b0111001;
    localparam logic [6:0] SEG_D = 7'b1011110;
    localparam logic [6:0] SEG_E = 7'b1111001;
    localparam logic [6:0] SEG_F = 7'b1110001;

    // Select codes as {led4, led3, led2, led1}
    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_D1   = 4'b0001;
    localparam logic [3:0] SEL_D2   = 4'b0010;
    localparam logic [3:0] SEL_D3   = 4'b0100;
    localparam logic [3:0] SEL_D4   = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GOT1 = 2'd1,
        GOT2 = 2'd2,
        GOT3 = 2'd3
    } scan_state_t;

    function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0:    pattern = SEG_0;
            4'h1:    pattern = SEG_1;
            4'h2:    pattern = SEG_2;
            4'h3:    pattern = SEG_3;
            4'h4:    pattern = SEG_4;
            4'h5:    pattern = SEG_5;
            4'h6:    pattern = SEG_6;
            4'h7:    pattern = SEG_7;
            4'h8:    pattern = SEG_8;
            4'h9:    pattern = SEG_9;
            4'hA:    pattern = SEG_A;
            4'hB:    pattern = SEG_B;
            4'hC:    pattern = SEG_C;
            4'hD:    pattern = SEG_D;
            4'hE:    pattern = SEG_E;
            4'hF:    pattern = SEG_F;
            default: pattern = 7'b0000000;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Combinational inverse of the segment table: pattern -> {hit, nibble}.
module seg7_pattern_decoder
    import seg7_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic       o_hit,
    output logic [3:0] o_nibble
);

    // Table lookup; anything outside the 16 hex glyphs is a miss
    always_comb begin
        o_hit    = 1'b1;
        o_nibble = 4'h0;
        case (i_pattern)
            SEG_0:   o_nibble = 4'h0;
            SEG_1:   o_nibble = 4'h1;
            SEG_2:   o_nibble = 4'h2;
            SEG_3:   o_nibble = 4'h3;
            SEG_4:   o_nibble = 4'h4;
            SEG_5:   o_nibble = 4'h5;
            SEG_6:   o_nibble = 4'h6;
            SEG_7:   o_nibble = 4'h7;
            SEG_8:   o_nibble = 4'h8;
            SEG_9:   o_nibble = 4'h9;
            SEG_A:   o_nibble = 4'hA;
            SEG_B:   o_nibble = 4'hB;
            SEG_C:   o_nibble = 4'hC;
            SEG_D:   o_nibble = 4'hD;
            SEG_E:   o_nibble = 4'hE;
            SEG_F:   o_nibble = 4'hF;
            default: begin
                o_hit    = 1'b0;
                o_nibble = 4'h0;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of the 4-digit multiplexed hex display: synchronizes and
// debounces the scanned bus, decodes digits and reassembles the 16-bit word.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic        led1,
    input  logic        led2,
    input  logic        led3,
    input  logic        led4,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        seg_error,
    output logic        sel_error
);

    localparam int SAMPLE_W = 11;
    localparam int CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYCLES - 1);

    logic [SAMPLE_W-1:0] r_sync [SYNC_STAGES];
    logic [SAMPLE_W-1:0] r_prev;
    logic [CNT_W-1:0]    r_cnt;
    scan_state_t         r_state;
    logic [3:0]          r_n0;
    logic [3:0]          r_n1;
    logic [3:0]          r_n2;
    logic [15:0]         r_value;
    logic                r_value_valid;
    logic                r_seg_error;
    logic                r_sel_error;

    logic [SAMPLE_W-1:0] w_sample;
    logic [3:0]          w_sel;
    logic                w_same;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_accept;
    logic                w_hit;
    logic [3:0]          w_nibble;

    assign w_sample = r_sync[SYNC_STAGES-1];
    assign w_sel    = w_sample[10:7];

    seg7_pattern_decoder u_pattern_decoder (
        .i_pattern (w_sample[6:0]),
        .o_hit     (w_hit),
        .o_nibble  (w_nibble)
    );

    // Input synchronizer chain for {led4..led1, seg}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= {SAMPLE_W{1'b0}};
            end
        end else begin
            r_sync[0] <= {led4, led3, led2, led1, seg};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Stability counter; the accept strobe fires only on the cycle the
    // count lands on STABLE_CYCLES-1, then the count parks at STABLE_CYCLES
    always_comb begin
        w_same = (w_sample == r_prev);
        if (!w_same) begin
            w_cnt_next = {CNT_W{1'b0}};
        end else if (r_cnt == CNT_MAX) begin
            w_cnt_next = r_cnt;
        end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
        w_accept = (w_cnt_next == CNT_ACC);
    end

    // Previous-sample and stability-count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= {SAMPLE_W{1'b0}};
            r_cnt  <= {CNT_W{1'b0}};
        end else begin
            r_prev <= w_sample;
            r_cnt  <= w_cnt_next;
        end
    end

    // Frame FSM with registered word and one-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_n0          <= 4'h0;
            r_n1          <= 4'h0;
            r_n2          <= 4'h0;
            r_value       <= 16'h0000;
            r_value_valid <= 1'b0;
            r_seg_error   <= 1'b0;
            r_sel_error   <= 1'b0;
        end else begin
            r_value_valid <= 1'b0;
            r_seg_error   <= 1'b0;
            r_sel_error   <= 1'b0;
            if (w_accept) begin
                case (w_sel)
                    SEL_NONE: begin
                        r_state <= r_state;
                    end
                    SEL_D1, SEL_D2, SEL_D3, SEL_D4: begin
                        if (!w_hit) begin
                            r_seg_error <= 1'b1;
                            r_state     <= IDLE;
                        end else if (w_sel == SEL_D1) begin
                            r_n0    <= w_nibble;
                            r_state <= GOT1;
                        end else if (w_sel == SEL_D2 && r_state == GOT1) begin
                            r_n1    <= w_nibble;
                            r_state <= GOT2;
                        end else if (w_sel == SEL_D3 && r_state == GOT2) begin
                            r_n2    <= w_nibble;
                            r_state <= GOT3;
                        end else if (w_sel == SEL_D4 && r_state == GOT3) begin
                            r_value       <= {w_nibble, r_n2, r_n1, r_n0};
                            r_value_valid <= 1'b1;
                            r_state       <= IDLE;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        // Multi-hot select wins over a bad pattern
                        r_sel_error <= 1'b1;
                        r_state     <= IDLE;
                    end
                endcase
            end else begin
                r_state <= r_state;
            end
        end
    end

    assign value       = r_value;
    assign value_valid = r_value_valid;
    assign seg_error   = r_seg_error;
    assign sel_error   = r_sel_error;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed scoreboard bench for seg7_scan_decoder (STABLE_CYCLES=4, SYNC_STAGES=2).
module tb_seg7_scan_decoder;

    localparam int STABLE = 4;
    localparam int SYNC   = 2;

    typedef struct packed {
        logic        valid;
        logic        seg_err;
        logic        sel_err;
        logic [15:0] value;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg;
    logic        led1, led2, led3, led4;
    logic [15:0] value;
    logic        value_valid, seg_error, sel_error;

    int          checks;
    int          errors;
    exp_t        exp_q[$];
    logic [15:0] last_value;
    logic [6:0]  pat_tab [16];

    seg7_scan_decoder #(.STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .led1        (led1),
        .led2        (led2),
        .led3        (led3),
        .led4        (led4),
        .value       (value),
        .value_valid (value_valid),
        .seg_error   (seg_error),
        .sel_error   (sel_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [3:0] sel, input logic [6:0] pat, input int cycles);
        {led4, led3, led2, led1} = sel;
        seg = pat;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic push_valid(input logic [15:0] v);
        exp_q.push_back('{valid: 1'b1, seg_err: 1'b0, sel_err: 1'b0, value: v});
        last_value = v;
    endtask

    task automatic push_err(input logic seg_e, input logic sel_e);
        exp_q.push_back('{valid: 1'b0, seg_err: seg_e, sel_err: sel_e, value: last_value});
    endtask

    // Full frame; digit nibbles d0 (led1) .. d3 (led4), pushes the expected word
    task automatic frame(input logic [15:0] v, input int hold);
        drive(4'b0001, pat_tab[v[3:0]], 8);
        drive(4'b0010, pat_tab[v[7:4]], 8);
        drive(4'b0100, pat_tab[v[11:8]], 8);
        push_valid(v);
        drive(4'b1000, pat_tab[v[15:12]], hold);
    endtask

    task automatic chk_drained(input string tag);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (value_valid || seg_error || sel_error) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_pulse observed valid=%0b seg_err=%0b sel_err=%0b value=%0h expected no pulse",
                       value_valid, seg_error, sel_error, value);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                assert ({value_valid, seg_error, sel_error, value} === {e.valid, e.seg_err, e.sel_err, e.value}) else begin
                    errors++;
                    $error("FAIL pulse_event observed v/se/sl/val=%0b/%0b/%0b/%0h expected %0b/%0b/%0b/%0h",
                           value_valid, seg_error, sel_error, value, e.valid, e.seg_err, e.sel_err, e.value);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        last_value = 16'h0000;
        pat_tab[0]  = 7'b0111111; pat_tab[1]  = 7'b0000110;
        pat_tab[2]  = 7'b1011011; pat_tab[3]  = 7'b1001111;
        pat_tab[4]  = 7'b1100110; pat_tab[5]  = 7'b1101101;
        pat_tab[6]  = 7'b1111101; pat_tab[7]  = 7'b0000111;
        pat_tab[8]  = 7'b1111111; pat_tab[9]  = 7'b1101111;
        pat_tab[10] = 7'b1110111; pat_tab[11] = 7'b1111100;
        pat_tab[12] = 7'b0111001; pat_tab[13] = 7'b1011110;
        pat_tab[14] = 7'b1111001; pat_tab[15] = 7'b1110001;

        rst_n = 1'b0;
        {led4, led3, led2, led1} = 4'b0000;
        seg = 7'b0000000;
        repeat (3) @(negedge clk);
        chk("reset_value", 32'(value), 32'h0000);
        chk("reset_pulses", 32'({value_valid, seg_error, sel_error}), 32'd0);
        rst_n = 1'b1;
        drive(4'b0000, 7'b0000000, 10);

        // Clean A5C3 frame with an exact latency check on the last digit
        drive(4'b0001, pat_tab[3], 8);
        drive(4'b0010, pat_tab[12], 8);
        drive(4'b0100, pat_tab[5], 8);
        push_valid(16'hA5C3);
        {led4, led3, led2, led1} = 4'b1000;
        seg = pat_tab[10];
        repeat (SYNC + STABLE - 1) @(negedge clk);
        chk("latency_early", 32'(value_valid), 32'd0);
        @(negedge clk);
        chk("latency_valid", 32'(value_valid), 32'd1);
        chk("latency_value", 32'(value), 32'hA5C3);
        repeat (2) @(negedge clk);
        chk_drained("a5c3_drained");

        // Same frame with a 2-cycle glitch inside digit2 and a long digit4
        drive(4'b0001, pat_tab[3], 8);
        drive(4'b0010, pat_tab[12], 3);
        drive(4'b0010, 7'b0000000, 2);
        drive(4'b0010, pat_tab[12], 8);
        drive(4'b0100, pat_tab[5], 8);
        push_valid(16'hA5C3);
        drive(4'b1000, pat_tab[10], 100);
        chk("glitch_value", 32'(value), 32'hA5C3);
        chk_drained("glitch_drained");

        // Non-hex pattern on digit2 aborts the frame, value held
        drive(4'b0001, pat_tab[3], 8);
        push_err(1'b1, 1'b0);
        drive(4'b0010, 7'b1010101, 8);
        drive(4'b0100, pat_tab[5], 8);
        drive(4'b1000, pat_tab[10], 8);
        chk("segerr_value_held", 32'(value), 32'hA5C3);
        chk_drained("segerr_drained");
        frame(16'h1234, 8);
        chk("frame_1234", 32'(value), 32'h1234);
        chk_drained("f1234_drained");

        // Multi-hot select after digit1, then orphan digits 2..4
        drive(4'b0001, pat_tab[1], 8);
        push_err(1'b0, 1'b1);
        drive(4'b0011, pat_tab[5], 8);
        drive(4'b0010, pat_tab[2], 8);
        drive(4'b0100, pat_tab[3], 8);
        drive(4'b1000, pat_tab[4], 8);
        chk("selerr_value_held", 32'(value), 32'h1234);
        chk_drained("selerr_drained");

        // Multi-hot select with a bad pattern: only the select error
        push_err(1'b0, 1'b1);
        drive(4'b0110, 7'b1010101, 8);
        chk_drained("both_bad_drained");

        // Blanking between digits does not break the frame
        drive(4'b0001, pat_tab[7], 8);
        drive(4'b0000, 7'b0000000, 8);
        drive(4'b0010, pat_tab[8], 8);
        drive(4'b0000, 7'b0000000, 8);
        drive(4'b0100, pat_tab[9], 8);
        drive(4'b0000, 7'b0000000, 8);
        push_valid(16'hB987);
        drive(4'b1000, pat_tab[11], 8);
        chk("blank_frame", 32'(value), 32'hB987);
        chk_drained("blank_drained");

        // Out of order: digit1 then digit3, then 2/3/4 without digit1
        drive(4'b0001, pat_tab[1], 8);
        drive(4'b0100, pat_tab[2], 8);
        drive(4'b0010, pat_tab[3], 8);
        drive(4'b0100, pat_tab[4], 8);
        drive(4'b1000, pat_tab[5], 8);
        chk("ooo_value_held", 32'(value), 32'hB987);
        chk_drained("ooo_drained");

        // Reset pulse while in GOT2
        drive(4'b0001, pat_tab[4], 8);
        drive(4'b0010, pat_tab[6], 8);
        chk("pre_reset_value", 32'(value), 32'hB987);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_value", 32'(value), 32'h0000);
        chk("mid_reset_pulses", 32'({value_valid, seg_error, sel_error}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_value = 16'h0000;
        drive(4'b0010, pat_tab[6], 4);
        chk("post_reset_value", 32'(value), 32'h0000);
        frame(16'hFFFF, 8);
        chk("frame_ffff", 32'(value), 32'hFFFF);

        drive(4'b0000, 7'b0000000, 20);
        chk_drained("final_drained");
        chk("final_value_held", 32'(value), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
